// File: rtl/ifetch.sv
// Instruction fetch unit: a sequential pc feeds a small FIFO of {pc, instr} pairs toward the decoder.
// Optional macro IFETCH_PERF_EN adds the perf_fetched / perf_stall counters.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int          PW    = $clog2(QDEPTH);
  localparam logic [PW:0] DEPTH = (PW + 1)'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic [31:0] instr_mem_q [QDEPTH];
  logic [31:0] pc_mem_q    [QDEPTH];

  logic full;
  logic pop;
  logic push;

  assign full      = (count_q == DEPTH);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A pop frees the slot being written, so a full queue can still accept a fetch.
  assign push      = !redirect_valid & (!full | pop);

  assign im_addr   = pc_q;
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PW + 1)'(1);
        2'b01:   count_d = count_q - (PW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_mem_q[wr_ptr_q] <= im_data;
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
    end else begin
      if (push) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (full && !pop) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed vector table, hand-written corner sequences and a
// randomized run against a queue-level reference model.
module tb_ifetch;

  localparam logic [31:0] RP0 = 32'h0000_0000;
  localparam int          D0  = 2;
  localparam logic [31:0] RP1 = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [31:0] im_addr0, im_data0, out_instr0, out_pc0;
  logic        out_valid0;
  logic [31:0] im_addr1, im_data1, out_instr1, out_pc1;
  logic        out_valid1;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched0, perf_stall0, perf_fetched1, perf_stall1;
`endif

  // Memory model: mem[i] = i, i.e. the word at byte address a is a>>2.
  assign im_data0 = im_addr0 >> 2;
  assign im_data1 = im_addr1 >> 2;

  ifetch #(.RESET_PC(RP0), .QDEPTH(D0)) dut0 (
    .clk(clk), .reset(reset), .im_addr(im_addr0), .im_data(im_data0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_instr(out_instr0), .out_pc(out_pc0)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched0), .perf_stall(perf_stall0)
`endif
  );

  ifetch #(.RESET_PC(RP1), .QDEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .im_addr(im_addr1), .im_data(im_data1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_instr(out_instr1), .out_pc(out_pc1)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched1), .perf_stall(perf_stall1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model for dut0: queue of fetched pcs plus the next fetch address.
  logic [31:0] mq[$];
  logic [31:0] mpc = RP0;
  bit          model_on = 0;
  // Expected next accepted pc on dut1 while no redirects are issued.
  logic [31:0] exp1 = RP1;
  bit          mon1_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive inputs for one cycle and sample outputs away from the edge.
  task automatic apply(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
    @(negedge clk);
    reset = r; redirect_valid = rv; redirect_pc = rp; out_ready = rd;
    #1;
    if (model_on) begin
      chk("model_valid", {31'h0, out_valid0}, {31'h0, mq.size() != 0});
      chk("model_pc",    out_pc0,    (mq.size() != 0) ? mq[0] : 32'h0);
      chk("model_instr", out_instr0, (mq.size() != 0) ? (mq[0] >> 2) : 32'h0);
      chk("model_addr",  im_addr0,   mpc);
    end
    if (mon1_on && !r && out_valid1 && rd) begin
      chk("dut1_seq_pc", out_pc1, exp1);
      chk("dut1_seq_instr", out_instr1, exp1 >> 2);
      exp1 = exp1 + 32'd4;
    end
  endtask

  task automatic advance();
    bit p;
    bit f;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      mpc  = RP0;
      exp1 = RP1;
    end else begin
      p = (mq.size() != 0) && out_ready;
      f = (mq.size() == D0);
      if (p) void'(mq.pop_front());
      if (redirect_valid) begin
        mq.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else if (!f || p) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rp;
    logic        rdy;
    logic        do_chk;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

    // Expected outputs are those visible during the row's cycle, before its edge.
    tbl[0]  = '{1, 0, 32'h0,   1, 0, 0, 32'h0,   32'h0};
    tbl[1]  = '{1, 1, 32'h100, 1, 1, 0, 32'h0,   32'h0};
    tbl[2]  = '{0, 0, 32'h0,   1, 1, 0, 32'h0,   32'h0};
    tbl[3]  = '{0, 0, 32'h0,   1, 1, 1, 32'h0,   32'h4};
    tbl[4]  = '{0, 0, 32'h0,   1, 1, 1, 32'h4,   32'h8};
    tbl[5]  = '{0, 0, 32'h0,   0, 1, 1, 32'h8,   32'hC};
    tbl[6]  = '{0, 0, 32'h0,   0, 1, 1, 32'h8,   32'h10};
    tbl[7]  = '{0, 0, 32'h0,   0, 1, 1, 32'h8,   32'h10};
    tbl[8]  = '{0, 1, 32'h43,  1, 1, 1, 32'h8,   32'h10};
    tbl[9]  = '{0, 0, 32'h0,   1, 1, 0, 32'h0,   32'h40};
    tbl[10] = '{0, 0, 32'h0,   1, 1, 1, 32'h40,  32'h44};
    tbl[11] = '{0, 1, 32'h200, 0, 1, 1, 32'h44,  32'h48};
    tbl[12] = '{0, 1, 32'h301, 1, 1, 0, 32'h0,   32'h200};
    tbl[13] = '{0, 0, 32'h0,   0, 1, 0, 32'h0,   32'h300};
    tbl[14] = '{0, 0, 32'h0,   0, 1, 1, 32'h300, 32'h304};
    tbl[15] = '{1, 1, 32'h500, 1, 1, 1, 32'h300, 32'h308};
    tbl[16] = '{0, 0, 32'h0,   1, 1, 0, 32'h0,   32'h0};
    tbl[17] = '{0, 0, 32'h0,   1, 1, 1, 32'h0,   32'h4};

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].rst, tbl[i].rv, tbl[i].rp, tbl[i].rdy);
      if (tbl[i].do_chk) begin
        chk($sformatf("vec%0d_valid", i), {31'h0, out_valid0}, {31'h0, tbl[i].ev});
        chk($sformatf("vec%0d_pc", i), out_pc0, tbl[i].epc);
        chk($sformatf("vec%0d_instr", i), out_instr0, tbl[i].ev ? (tbl[i].epc >> 2) : 32'h0);
        chk($sformatf("vec%0d_addr", i), im_addr0, tbl[i].eaddr);
        $display("vec %0d: valid=%0b pc=%h instr=%h addr=%h", i, out_valid0, out_pc0, out_instr0, im_addr0);
      end
      advance();
    end

    // Stall with out_ready low: two entries queued, fetch address parked at 8.
    apply(1, 0, 32'h0, 0); advance();
    model_on = 1;
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 32'h0, 0); advance();
    end
    apply(0, 0, 32'h0, 0);
    chk("stall_addr", im_addr0, 32'h8);
    chk("stall_head", out_pc0, 32'h0);
`ifdef IFETCH_PERF_EN
    chk("stall_perf_stall", perf_stall0, 32'd3);
    chk("stall_perf_fetched", perf_fetched0, 32'd2);
`endif
    $display("stall: addr=%h head=%h", im_addr0, out_pc0);
    advance();

    // Redirect from a full queue while the head is accepted.
    apply(0, 1, 32'h43, 1);
    chk("redir_head", out_pc0, 32'h0);
    advance();
    apply(0, 0, 32'h0, 1);
    chk("redir_bubble_valid", {31'h0, out_valid0}, 32'h0);
    chk("redir_bubble_addr", im_addr0, 32'h40);
    advance();
    apply(0, 0, 32'h0, 1);
    chk("redir_target_pc", out_pc0, 32'h40);
    $display("redirect: target pc=%h", out_pc0);
    advance();

    // Reset while two entries are held and a redirect is requested.
    apply(0, 0, 32'h0, 0); advance();
    apply(0, 0, 32'h0, 0); advance();
    apply(1, 1, 32'h800, 1); advance();
    apply(0, 0, 32'h0, 0);
    chk("rst_over_valid", {31'h0, out_valid0}, 32'h0);
    chk("rst_over_addr", im_addr0, RP0);
    $display("reset override: valid=%0b addr=%h", out_valid0, im_addr0);
    advance();

    // Wrap of the fetch address on dut1 (RESET_PC = FFFF_FFF8).
    apply(1, 0, 32'h0, 1); advance();
    apply(0, 0, 32'h0, 1);
    chk("wrap_first_valid", {31'h0, out_valid1}, 32'h0);
    advance();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = RP1 + 32'(4 * i);
      apply(0, 0, 32'h0, 1);
      chk($sformatf("wrap_pc%0d", i), out_pc1, e);
      $display("wrap %0d: out_pc=%h", i, out_pc1);
      advance();
    end

    // Random out_ready, no redirects: gap-free consecutive streams.
    apply(1, 0, 32'h0, 0); advance();
    mon1_on = 1;
    for (int i = 0; i < 1000; i++) begin
      apply(0, 0, 32'h0, 1'($urandom_range(0, 1))); advance();
    end
    mon1_on = 0;
    $display("random stream: dut1 next expected pc=%h", exp1);

    // Random mix with redirects and occasional reset, model only.
    for (int i = 0; i < 500; i++) begin
      logic r;
      logic rv;
      r  = ($urandom_range(0, 49) == 0);
      rv = ($urandom_range(0, 7) == 0);
      apply(r, rv, $urandom, 1'($urandom_range(0, 1))); advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
